// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, address field positions and FSM encoding shared by the dcache_ctrl slice.
package dcache_pkg;
   localparam int TAG_W    = 25;
   localparam int IDX_W    = 3;
   localparam int BLK_W    = 128;
   localparam int SETS     = 1 << IDX_W;
   localparam int MADDR_W  = 28;
   localparam int TAG_LSB  = 7;
   localparam int IDX_LSB  = 4;
   localparam int WORD_LSB = 2;
   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
   function automatic logic [31:0] word_sel(logic [BLK_W-1:0] blk, logic [1:0] w);
      return blk[{w, 5'd0} +: 32];
   endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU-side request/response and block-memory READ/WRITE/BUSYWAIT signals of the data cache.
interface dcache_if;
   logic                        cpu_read;
   logic                        cpu_write;
   logic [31:0]                 cpu_addr;
   logic [31:0]                 cpu_wdata;
   logic [3:0]                  cpu_byte_en;
   logic [31:0]                 cpu_rdata;
   logic                        cpu_busywait;
   logic                        mem_read;
   logic                        mem_write;
   logic [dcache_pkg::MADDR_W-1:0] mem_addr;
   logic [dcache_pkg::BLK_W-1:0]   mem_wdata;
   logic [dcache_pkg::BLK_W-1:0]   mem_rdata;
   logic                        mem_busywait;
   modport master (
      input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_byte_en, mem_rdata, mem_busywait,
      output cpu_rdata, cpu_busywait, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport slave (
      output cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_byte_en, mem_rdata, mem_busywait,
      input  cpu_rdata, cpu_busywait, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays with a fill port, a byte-lane write port and async read.
module dcache_line_store
   import dcache_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic [IDX_W-1:0] idx,
   input  logic             fill_data_en,
   input  logic [BLK_W-1:0] fill_data,
   input  logic             fill_tag_en,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic             wr_en,
   input  logic [1:0]       wr_word,
   input  logic [3:0]       wr_be,
   input  logic [31:0]      wr_data,
   output logic             valid,
   output logic             dirty,
   output logic [TAG_W-1:0] tag,
   output logic [BLK_W-1:0] data
);
   logic [SETS-1:0]  valid_q, dirty_q;
   logic [TAG_W-1:0] tag_q [SETS];
   logic [BLK_W-1:0] data_q [SETS];

   assign valid = valid_q[idx];
   assign dirty = dirty_q[idx];
   assign tag   = tag_q[idx];
   assign data  = data_q[idx];

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_tag_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (wr_en)
         dirty_q[idx] <= 1'b1;

   // Tag and data contents need no reset; valid gates every use.
   always_ff @(posedge CLK) begin
      if (fill_tag_en)
         tag_q[idx] <= fill_tag;
      if (fill_data_en)
         data_q[idx] <= fill_data;
      else if (wr_en)
         for (int b = 0; b < 4; b++)
            if (wr_be[b])
               data_q[idx][{wr_word, b[1:0], 3'd0} +: 8] <= wr_data[8*b +: 8];
   end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate data cache controller (8 x 16 B lines).
// Defining DCACHE_STATS_EN adds hit_count/miss_count statistics outputs.
module dcache_ctrl
   import dcache_pkg::*;
(
   input logic      CLK,
   input logic      RESET,
   dcache_if.master bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   state_t           state;
   logic             valid, dirty, hit, req, idle, evict;
   logic [TAG_W-1:0] tag, req_tag;
   logic [IDX_W-1:0] idx;
   logic [BLK_W-1:0] data;
   logic [1:0]       word;

   assign idx     = bus.cpu_addr[IDX_LSB +: IDX_W];
   assign req_tag = bus.cpu_addr[TAG_LSB +: TAG_W];
   assign word    = bus.cpu_addr[WORD_LSB +: 2];
   assign req     = bus.cpu_read || bus.cpu_write;
   assign idle    = state == IDLE;
   assign hit     = valid && tag == req_tag;
   assign evict   = valid && dirty;

   assign bus.cpu_busywait = !idle || (req && !hit);
   assign bus.cpu_rdata    = idle && hit ? word_sel(data, word) : '0;

   // A simultaneous read+write is served as a read, so stores require cpu_read low.
   dcache_line_store store (
      .CLK,
      .RESET,
      .idx,
      .fill_data_en(state == FETCH && !bus.mem_busywait),
      .fill_data(bus.mem_rdata),
      .fill_tag_en(state == UPDATE),
      .fill_tag(req_tag),
      .wr_en(idle && hit && bus.cpu_write && !bus.cpu_read),
      .wr_word(word),
      .wr_be(bus.cpu_byte_en),
      .wr_data(bus.cpu_wdata),
      .valid,
      .dirty,
      .tag,
      .data
   );

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state         <= IDLE;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else
         case (state)
            IDLE:
               if (req && !hit) begin
                  state         <= evict ? WRITEBACK : FETCH;
                  bus.mem_write <= evict;
                  bus.mem_read  <= !evict;
                  bus.mem_addr  <= evict ? {tag, idx} : bus.cpu_addr[31:IDX_LSB];
                  bus.mem_wdata <= data;
               end
            WRITEBACK:
               if (!bus.mem_busywait) begin
                  state         <= FETCH;
                  bus.mem_write <= 1'b0;
                  bus.mem_read  <= 1'b1;
                  bus.mem_addr  <= bus.cpu_addr[31:IDX_LSB];
               end
            FETCH:
               if (!bus.mem_busywait) begin
                  state        <= UPDATE;
                  bus.mem_read <= 1'b0;
               end
            default: state <= IDLE;
         endcase

`ifdef DCACHE_STATS_EN
   logic missed;
   // missed marks a request that had to refill, so its final hit is not counted.
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         hit_count  <= '0;
         miss_count <= '0;
         missed     <= 1'b0;
      end else begin
         if (idle && req && hit) begin
            if (!missed)
               hit_count <= hit_count + 32'd1;
            missed <= 1'b0;
         end else if (idle && req)
            missed <= 1'b1;
         if ((idle && req && !hit && !evict) || (state == WRITEBACK && !bus.mem_busywait))
            miss_count <= miss_count + 32'd1;
      end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl against a block-memory model with stretchable busywait.
module tb_dcache_ctrl;
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   dcache_if bus();
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache_ctrl dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count(hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct { logic rd; logic [31:0] data; int stalls; string name; } cpu_exp_t;
   typedef struct { logic wr; logic [27:0] addr; logic [31:0] w0; string name; } mem_exp_t;
   cpu_exp_t cpu_q[$];
   mem_exp_t mem_q[$];
   cpu_exp_t e;
   mem_exp_t m;
   int checks = 0;
   int passes = 0;
   int stalls = 0;
   int lat = 0;
   int wcnt = 0;
   logic [127:0] mem [32];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Block memory: busywait held for lat cycles per request, writes land on completion.
   assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && wcnt < lat;
   assign bus.mem_rdata    = mem[bus.mem_addr[4:0]];
   always @(posedge CLK) begin
      wcnt <= bus.mem_busywait ? wcnt + 1 : 0;
      if (bus.mem_write && !bus.mem_busywait) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
   end

   always @(negedge CLK) begin
      if (RESET) stalls = 0;
      else if (bus.cpu_read || bus.cpu_write) begin
         if (bus.cpu_busywait) stalls++;
         else begin
            if (cpu_q.size() == 0) chk("cpu_unexpected", 1, 0);
            else begin
               e = cpu_q.pop_front();
               if (e.rd) chk({e.name, "_rdata"}, bus.cpu_rdata, e.data);
               chk({e.name, "_stalls"}, stalls, e.stalls);
            end
            stalls = 0;
         end
      end
   end

   logic act_p = 1'b0;
   logic wr_p = 1'b0;
   logic [27:0] addr_p = '0;
   logic [127:0] wd_p = '0;
   always @(negedge CLK) begin
      if (bus.mem_read || bus.mem_write) begin
         chk("mem_exclusive", bus.mem_read && bus.mem_write, 0);
         chk("mem_cpu_stall", bus.cpu_busywait, 1);
         if (!act_p || wr_p != bus.mem_write) begin
            if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
            else begin
               m = mem_q.pop_front();
               chk({m.name, "_kind"}, bus.mem_write, m.wr);
               chk({m.name, "_addr"}, bus.mem_addr, m.addr);
               if (m.wr) chk({m.name, "_wdata0"}, bus.mem_wdata[31:0], m.w0);
            end
         end else begin
            chk("mem_addr_held", bus.mem_addr, addr_p);
            if (wr_p) chk("mem_wdata_held", bus.mem_wdata, wd_p);
         end
         act_p  = 1'b1;
         wr_p   = bus.mem_write;
         addr_p = bus.mem_addr;
         wd_p   = bus.mem_wdata;
      end else act_p = 1'b0;
   end

   task automatic mexp(input logic wr, input logic [27:0] addr, input logic [31:0] w0, input string name);
      mem_q.push_back('{wr, addr, w0, name});
   endtask

   task automatic issue(input string name, input logic rd, wr, input logic [31:0] addr, wd,
                        input logic [3:0] be, input logic [31:0] exp, input int st);
      int n = 0;
      cpu_q.push_back('{rd, exp, st, name});
      bus.cpu_read = rd;
      bus.cpu_write = wr;
      bus.cpu_addr = addr;
      bus.cpu_wdata = wd;
      bus.cpu_byte_en = be;
      do begin @(negedge CLK); n++; end while (bus.cpu_busywait && n < 200);
      if (n >= 200) chk({name, "_timeout"}, 1, 0);
      @(posedge CLK); #1;
      bus.cpu_read = 1'b0;
      bus.cpu_write = 1'b0;
   endtask

   task automatic rst_checks(input string name);
      chk({name, "_cpu_busywait"}, bus.cpu_busywait, 0);
      chk({name, "_cpu_rdata"}, bus.cpu_rdata, 0);
      chk({name, "_mem_read"}, bus.mem_read, 0);
      chk({name, "_mem_write"}, bus.mem_write, 0);
      chk({name, "_mem_addr"}, bus.mem_addr, 0);
      chk({name, "_mem_wdata"}, bus.mem_wdata, 0);
`ifdef DCACHE_STATS_EN
      chk({name, "_hit_count"}, hit_count, 0);
      chk({name, "_miss_count"}, miss_count, 0);
`endif
   endtask

   initial begin
      int n;
      bus.cpu_read = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_wdata = '0;
      bus.cpu_byte_en = '0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem[4]  <= {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      mem[12] <= {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      mem[21] <= {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
      #2 RESET = 1'b1;
      #4 rst_checks("por");
      @(negedge CLK); #1 RESET = 1'b0;
      @(posedge CLK); #1;

      mexp(1'b0, 28'h4, 0, "cold_fill");
      issue("cold_lw40", 1, 0, 32'h40, 0, 4'b0000, 32'hAAAAAAAA, 3);
      issue("sb_hit", 0, 1, 32'h41, 32'h00005A00, 4'b0010, 0, 0);
      issue("lw_after_sb", 1, 0, 32'h40, 0, 4'b0000, 32'hAAAA5AAA, 0);
      mexp(1'b1, 28'h4, 32'hAAAA5AAA, "victim_wb");
      mexp(1'b0, 28'hC, 0, "conflict_fill");
      issue("conflict_lwc0", 1, 0, 32'hC0, 0, 4'b0000, 32'h11111111, 4);
`ifdef DCACHE_STATS_EN
      chk("stats_hits_a", hit_count, 2);
      chk("stats_misses_a", miss_count, 2);
`endif

      lat = 5;
      mexp(1'b0, 28'h15, 0, "slow_fill");
      issue("slow_lw154", 1, 0, 32'h154, 0, 4'b0000, 32'h55550001, 8);
      lat = 0;
      issue("sh_hit", 0, 1, 32'h156, 32'hBEEF0000, 4'b1100, 0, 0);
      issue("rd_wr_both", 1, 1, 32'h154, 32'hFFFFFFFF, 4'b1111, 32'hBEEF0001, 0);
      issue("lw_after_both", 1, 0, 32'h154, 0, 4'b0000, 32'hBEEF0001, 0);
`ifdef DCACHE_STATS_EN
      chk("stats_hits_b", hit_count, 5);
      chk("stats_misses_b", miss_count, 3);
`endif

      // Clean miss on set 4, then reset while the fill is still waiting on memory.
      lat = 3;
      mexp(1'b0, 28'h4, 0, "abandoned_fill");
      bus.cpu_read = 1'b1;
      bus.cpu_addr = 32'h40;
      n = 0;
      do begin @(negedge CLK); n++; end while (!bus.mem_read && n < 20);
      chk("rst_fetch_started", bus.mem_read, 1);
      @(posedge CLK); #2;
      RESET = 1'b1;
      bus.cpu_read = 1'b0;
      #1 rst_checks("mid_fetch_rst");
      @(negedge CLK); #1 RESET = 1'b0;
      lat = 0;
      @(posedge CLK); #1;

      mexp(1'b0, 28'h4, 0, "refill_40");
      issue("relw_40", 1, 0, 32'h40, 0, 4'b0000, 32'hAAAA5AAA, 3);
      mexp(1'b0, 28'h15, 0, "refill_154");
      issue("relw_154", 1, 0, 32'h154, 0, 4'b0000, 32'h55550001, 3);
`ifdef DCACHE_STATS_EN
      chk("stats_hits_c", hit_count, 0);
      chk("stats_misses_c", miss_count, 2);
`endif
      repeat (3) @(posedge CLK);
      chk("cpu_q_drained", cpu_q.size(), 0);
      chk("mem_q_drained", mem_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected finish before 100000");
      $fatal(1);
   end
endmodule
